attention_sv: RTL
=================

# attention_sv

Downstream stage of the attention QKᵀ score block. It takes the 4x4 score matrix S and the 4x16 value matrix V, and produces the 4x16 output O = S·V. The datapath is a 16-lane signed multiply-accumulate time-multiplexed over 16 cycles, with valid/ready handshakes on both sides. It sits between score generation and the attention output register/projection stage.

## Interface
- N, 4: sequence rows (S is NxN, V and O are NxD)
- D, 16: embedding columns
- DW, 8: signed element width of S and V
- ACC_W, 2*DW+$clog2(N) = 18: signed output element width; sized so the result never overflows

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  S/V payload valid
- in_ready  out  1  block can accept a payload
- S  in  N*N*DW (128)  element (i,k) at S[(i*N+k)*DW +: DW], signed
- V  in  N*D*DW (512)  element (k,j) at V[(k*D+j)*DW +: DW], signed
- out_valid  out  1  O holds a complete result
- out_ready  in  1  consumer takes O
- O  out  N*D*ACC_W (1152)  element (i,j) at O[(i*D+j)*ACC_W +: ACC_W], signed
- busy  out  1  high in COMPUTE

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready: register S and V, clear O to 0, clear counters row=0 and k=0, go to COMPUTE.
- COMPUTE: one step per cycle, with step c = row*N + k (c = 0..15).
  - For every j: O(row,j) += sext(S(row,k)) * sext(V(k,j)).
  - Products are full 2*DW signed. The accumulation is ACC_W signed with no saturation; none is needed.
  - k increments each cycle and wraps 3→0. When k wraps, row increments.
  - After step (row=3, k=3), go to DONE.
- DONE: out_valid=1. O and all internal state are frozen.
  - On out_valid && out_ready, go to IDLE.
- Inputs S and V are sampled only on the accept edge. Changes to them afterwards have no effect.
- in_valid is ignored outside IDLE. Only one transaction is in flight at a time; there is no overlap.
- O is only meaningful while out_valid=1. During COMPUTE it holds partial sums.

## Timing
- Reset values (asynchronous assert): state=IDLE, in_ready=1, out_valid=0, busy=0, O=0, counters=0, captured S/V=0.
- Latency: with acceptance at edge t, the compute steps occur on edges t+1 … t+16, and out_valid is high from edge t+16.
- in_ready = (state==IDLE), out_valid = (state==DONE), busy = (state==COMPUTE). All three are decoded from registered state, with no combinational path from inputs.
- Output handshake at edge u: out_valid=0 and in_ready=1 from edge u. The earliest next accept is edge u+1.
- Throughput with out_ready held high: one result per 18 cycles.
- out_ready low in DONE: hold indefinitely with O stable bit-for-bit.
- out_ready high before DONE has no effect.
- Reset mid-operation (any state): abort immediately to the reset values. No partial result is presented.

## Structure
- Package attention_pkg holds:
  - N, D, DW, ACC_W constants.
  - state_t enum {IDLE, COMPUTE, DONE}.
  - Element index helper functions for S, V and O flat packing, matching the QKᵀ block's flat-vector style.
- Sub-module attention_mac_row: combinational, D lanes.
  - Inputs: scalar s (DW), V row vector (D*DW), accumulator row (D*ACC_W).
  - Output: updated accumulator row.
- The top level holds the FSM, the counters, the captured S/V registers and the O register, and muxes the selected S element and V row into attention_mac_row.

## Test plan
1. Reset.
   - Assert reset_n=0 mid-idle: out_valid=0, in_ready=1, busy=0, O=0.
   - Release reset: state unchanged until in_valid.
2. Identity scores.
   - Input: S(i,k) = (i==k) ? 1 : 0, V(k,j) = k*16+j-64.
   - Required: O(i,j) = i*16+j-64 (e.g. O(0,0)=-64, O(3,15)=-1), with out_valid high exactly 16 edges after the accept edge.
3. Extremes.
   - All S=-128, all V=-128: every O=65536 (0x10000).
   - All S=-128, all V=127: every O=-65024.
   - All S=127, all V=127: every O=64516.
4. Backpressure.
   - Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new data: O unchanged, in_ready=0, new data not captured.
   - Raise out_ready: in_ready=1 on the next cycle, and the held in_valid payload is accepted one edge later.
5. Reset mid-compute.
   - Assert reset_n=0 at step 8: O=0, out_valid=0, in_ready=1 immediately.
   - Follow-up transaction (scenario 2 data): correct results.
6. Back-to-back.
   - Hold in_valid=1 and out_ready=1 over three transactions with random signed S and V: results match the reference model, with out_valid pulses 18 cycles apart.

Source files
------------

// File: rtl/attention_pkg.sv
// Shared constants, FSM state type and flat-vector index helpers for the
// attention S*V output stage.
package attention_pkg;

    localparam int N     = 4;
    localparam int D     = 16;
    localparam int DW    = 8;
    localparam int ACC_W = 2*DW + $clog2(N);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    // Bit offsets of element (i,k) of S, (k,j) of V and (i,j) of O.
    function automatic int s_idx(input int i, input int k);
        return (i*N + k) * DW;
    endfunction

    function automatic int v_idx(input int k, input int j);
        return (k*D + j) * DW;
    endfunction

    function automatic int o_idx(input int i, input int j);
        return (i*D + j) * ACC_W;
    endfunction

endpackage

// File: rtl/attention_mac_row.sv
// One O row update: acc_out(j) = acc_in(j) + s * v_row(j) across D signed lanes.
module attention_mac_row
    import attention_pkg::*;
(
    input  logic signed [DW-1:0]      s,
    input  logic        [D*DW-1:0]    v_row,
    input  logic        [D*ACC_W-1:0] acc_in,
    output logic        [D*ACC_W-1:0] acc_out
);

    for (genvar j = 0; j < D; j++) begin : g_lane
        logic signed [DW-1:0]    v_el;
        logic signed [2*DW-1:0]  prod;
        logic signed [ACC_W-1:0] acc;

        assign v_el = v_row[j*DW +: DW];
        assign prod = s * v_el;
        assign acc  = acc_in[j*ACC_W +: ACC_W];
        // ACC_W carries log2(N) guard bits, so the sum cannot wrap.
        assign acc_out[j*ACC_W +: ACC_W] = acc + ACC_W'(prod);
    end

endmodule

// File: rtl/attention_sv.sv
// O = S*V stage: captures a 4x4 score matrix and a 4x16 value matrix, then
// accumulates one S element times one V row per cycle over 16 cycles.
module attention_sv
    import attention_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*N*DW-1:0]      S,
    input  logic [N*D*DW-1:0]      V,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*D*ACC_W-1:0]   O,
    output logic                   busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       row_q, k_q;
    logic [N*N*DW-1:0]      s_q;
    logic [N*D*DW-1:0]      v_q;
    logic [N*D*ACC_W-1:0]   o_q;

    logic                   last_step;
    int                     s_base;
    logic signed [DW-1:0]   s_sel;
    logic [D*DW-1:0]        v_row;
    logic [D*ACC_W-1:0]     acc_row, acc_row_next;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COMPUTE);
    assign O         = o_q;

    assign last_step = (row_q == LAST) && (k_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = COMPUTE;
            COMPUTE: if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand selection for the current step c = row*N + k.
    assign s_base  = s_idx(int'(row_q), int'(k_q));
    assign s_sel   = s_q[s_base +: DW];
    assign v_row   = v_q[int'(k_q)*D*DW +: D*DW];
    assign acc_row = o_q[int'(row_q)*D*ACC_W +: D*ACC_W];

    attention_mac_row u_mac_row (
        .s       (s_sel),
        .v_row   (v_row),
        .acc_in  (acc_row),
        .acc_out (acc_row_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q   <= '0;
            v_q   <= '0;
            o_q   <= '0;
            row_q <= '0;
            k_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q   <= S;
                        v_q   <= V;
                        o_q   <= '0;
                        row_q <= '0;
                        k_q   <= '0;
                    end
                end
                COMPUTE: begin
                    o_q[int'(row_q)*D*ACC_W +: D*ACC_W] <= acc_row_next;
                    // Both counters wrap back to zero after the final step.
                    k_q <= k_q + 1'b1;
                    if (k_q == LAST) row_q <= row_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
